// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
// Shared types and constants for the pipelined bitwise logic unit.
//   OP_W : width of the operation code
//   op_e : operation encoding (AND, OR, XOR, NAND, NOR, XNOR, ANDN, PASS)
// -----------------------------------------------------------------------------
package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_ANDN = 3'b110,   // A & ~B
        OP_PASS = 3'b111    // A
    } op_e;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe_if
// Bundles the operand handshake, result handshake and accumulator signals of
// logic_unit_pipe.
//   master : operand issue / writeback side (drives operands and out_ready)
//   slave  : the logic unit itself
// Optional flag outputs out_zero / out_parity exist only when
// LOGIC_UNIT_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
interface logic_unit_pipe_if
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [OP_W-1:0]  in_op;
    logic             in_acc_sel;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] acc_out;
`ifdef LOGIC_UNIT_FLAGS_EN
    logic             out_zero;
    logic             out_parity;

    modport master (
        output in_valid, in_a, in_b, in_op, in_acc_sel, acc_clr, out_ready,
        input  in_ready, out_valid, out_data, acc_out, out_zero, out_parity
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_acc_sel, acc_clr, out_ready,
        output in_ready, out_valid, out_data, acc_out, out_zero, out_parity
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_op, in_acc_sel, acc_clr, out_ready,
        input  in_ready, out_valid, out_data, acc_out
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_acc_sel, acc_clr, out_ready,
        output in_ready, out_valid, out_data, acc_out
    );
`endif

endinterface

// File: rtl/logic_unit_core.sv
// -----------------------------------------------------------------------------
// logic_unit_core
// Combinational WIDTH-bit bitwise evaluator.
//   a_i  : operand A (already muxed with the accumulator by the caller)
//   b_i  : operand B
//   op_i : operation select
//   y_o  : result, pure bitwise, no carry
// -----------------------------------------------------------------------------
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_e              op_i,
    output logic [WIDTH-1:0] y_o
);

    // NOTE: every output of an always_comb gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        y_o = '0;
        case (op_i)
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NAND: y_o = ~(a_i & b_i);
            OP_NOR:  y_o = ~(a_i | b_i);
            OP_XNOR: y_o = ~(a_i ^ b_i);
            OP_ANDN: y_o = a_i & ~b_i;
            OP_PASS: y_o = a_i;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
// Two-stage pipelined bitwise logic unit with valid/ready handshakes,
// full-throughput backpressure and a result accumulator for chained ops.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : logic_unit_pipe_if.slave
//           in_valid/in_ready/in_a/in_b/in_op/in_acc_sel : operand handshake
//           out_valid/out_ready/out_data                 : result handshake
//           acc_clr : synchronous accumulator clear (beats a load)
//           acc_out : current accumulator value
// Stage S0 registers the operands; stage S1 evaluates and registers the result.
// Optional feature: define LOGIC_UNIT_FLAGS_EN to add registered out_zero and
// out_parity flags that travel with out_data.
// -----------------------------------------------------------------------------
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_unit_pipe_if.slave   bus
);

    // S0 operand stage
    logic             s0_valid_q, s0_valid_d;
    logic [WIDTH-1:0] s0_a_q, s0_a_d;
    logic [WIDTH-1:0] s0_b_q, s0_b_d;
    op_e              s0_op_q, s0_op_d;
    logic             s0_acc_sel_q, s0_acc_sel_d;

    // S1 result stage and accumulator
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             adv1;
    logic             in_ready;
    logic [WIDTH-1:0] eff_a;
    logic [WIDTH-1:0] result;

    // S0 moves into S1 whenever S1 is empty or being drained this cycle.
    assign adv1     = s0_valid_q & (~out_valid_q | bus.out_ready);
    assign in_ready = ~s0_valid_q | adv1;

    // The accumulator is loaded on the same edge that S1 captures a result,
    // so the next transaction (now in S0) sees it without a bubble.
    assign eff_a = s0_acc_sel_q ? acc_q : s0_a_q;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .a_i  (eff_a),
        .b_i  (s0_b_q),
        .op_i (s0_op_q),
        .y_o  (result)
    );

    always_comb begin
        s0_valid_d   = s0_valid_q;
        s0_a_d       = s0_a_q;
        s0_b_d       = s0_b_q;
        s0_op_d      = s0_op_q;
        s0_acc_sel_d = s0_acc_sel_q;
        if (in_ready) begin
            s0_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s0_a_d       = bus.in_a;
                s0_b_d       = bus.in_b;
                s0_op_d      = op_e'(bus.in_op);
                s0_acc_sel_d = bus.in_acc_sel;
            end
        end

        // A held result stays put until taken; out_data only changes on adv1.
        out_valid_d = adv1 | (out_valid_q & ~bus.out_ready);
        out_data_d  = adv1 ? result : out_data_q;

        acc_d = acc_q;
        if (bus.acc_clr) begin
            acc_d = '0;
        end else if (adv1) begin
            acc_d = result;
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q   <= 1'b0;
            s0_a_q       <= '0;
            s0_b_q       <= '0;
            s0_op_q      <= OP_AND;
            s0_acc_sel_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            acc_q        <= '0;
        end else begin
            s0_valid_q   <= s0_valid_d;
            s0_a_q       <= s0_a_d;
            s0_b_q       <= s0_b_d;
            s0_op_q      <= s0_op_d;
            s0_acc_sel_q <= s0_acc_sel_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            acc_q        <= acc_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.acc_out   = acc_q;

`ifdef LOGIC_UNIT_FLAGS_EN
    logic zero_q, zero_d;
    logic parity_q, parity_d;

    always_comb begin
        zero_d   = adv1 ? (result == '0) : zero_q;
        parity_d = adv1 ? (^result)      : parity_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            zero_q   <= zero_d;
            parity_q <= parity_d;
        end
    end

    assign bus.out_zero   = zero_q;
    assign bus.out_parity = parity_q;
`endif

endmodule
